robot_bbox_pipe: RTL and testbench

- Upstream stage of the robot icon renderer. Captures the Rojobot LocX/LocY/BotInfo registers when the bot signals an update.
- Computes the scaled screen bounding box with a pipelined, shared multiplier, which removes the multiply from the pixel path.
- Holds the result in a pending buffer and commits it to the display set only at a frame boundary, so the icon never tears mid-frame.
- Its registered outputs feed the icon lookup directly.

---
 rtl/robot_disp_pkg.sv | 22 ++
 rtl/bbox_axis_calc.sv | 26 ++
 rtl/robot_bbox_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_robot_bbox_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_disp_pkg.sv
// Shared constants and types for the robot icon display path: world-to-screen
// scaling, sprite geometry, the bounding-box FSM encoding and the screen
// coordinate type.
package robot_disp_pkg;

    localparam int SCALING_FACTOR = 6;
    localparam int SPRITE_COLS    = 34;
    localparam int SPRITE_ROWS    = 34;
    localparam int CTB_X          = (SPRITE_COLS - SCALING_FACTOR) / 2;
    localparam int CTB_Y          = (SPRITE_ROWS - SCALING_FACTOR) / 2;

    localparam int COORD_W = 16;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2
    } bbox_state_e;

endpackage

// File: rtl/bbox_axis_calc.sv
// One-axis bounding-box calculator. A single world coordinate is scaled to
// screen pixels, then widened by the centre-to-bound offset on each side:
//   lo = loc*S - ctb
//   hi = (loc+1)*S - 1 + ctb
// Used once by the pipe and time-shared between the X and Y axes.
module bbox_axis_calc
    import robot_disp_pkg::*;
(
    input  logic [7:0] loc_i,
    input  coord_t     ctb_i,
    output coord_t     lo_o,
    output coord_t     hi_o
);

    coord_t loc_ext;
    coord_t scaled;

    // Zero-extend the world coordinate and do all arithmetic in 16-bit signed.
    always_comb begin
        loc_ext = $signed({8'd0, loc_i});
        scaled  = loc_ext * coord_t'(SCALING_FACTOR);
        lo_o    = scaled - ctb_i;
        hi_o    = scaled + coord_t'(SCALING_FACTOR - 1) + ctb_i;
    end

endmodule

// File: rtl/robot_bbox_pipe.sv
// Robot bounding-box pipe. Captures LocX/LocY/BotInfo on an update pulse,
// computes the screen bounding box over two cycles with one shared axis
// calculator (X then Y), parks the result in a pending buffer and commits it
// to the display outputs only on frame_tick, so the icon never tears.
//
// Pulse semantics: upd_sysregs and frame_tick are one-cycle strobes sampled on
// the rising clock edge; there is no back-pressure. A new update always wins
// over an in-flight calculation, and the last completed result is the one
// that commits.
//
// Optional build macro ROBOT_BBOX_STATS_EN adds coalesced_cnt and commit_cnt.
module robot_bbox_pipe
    import robot_disp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         LocX_reg,
    input  logic [7:0]         LocY_reg,
    input  logic [7:0]         BotInfo_reg,
    input  logic               upd_sysregs,
    input  logic               frame_tick,
    output logic signed [15:0] bbox_left,
    output logic signed [15:0] bbox_right,
    output logic signed [15:0] bbox_top,
    output logic signed [15:0] bbox_bottom,
    output logic [7:0]         bot_info_disp,
    output logic               bbox_valid,
    output logic               busy
`ifdef ROBOT_BBOX_STATS_EN
    ,
    output logic [15:0]        coalesced_cnt,
    output logic [15:0]        commit_cnt
`endif
);

    bbox_state_e state_q, state_d;

    // Captured inputs for the calculation in flight
    logic [7:0] cap_x_q, cap_x_d;
    logic [7:0] cap_y_q, cap_y_d;
    logic [7:0] cap_info_q, cap_info_d;

    // X half of the in-flight result, held until Y completes
    coord_t calc_left_q, calc_left_d;
    coord_t calc_right_q, calc_right_d;

    // Completed result waiting for a frame boundary
    coord_t     pend_left_q, pend_left_d;
    coord_t     pend_right_q, pend_right_d;
    coord_t     pend_top_q, pend_top_d;
    coord_t     pend_bottom_q, pend_bottom_d;
    logic [7:0] pend_info_q, pend_info_d;
    logic       pend_valid_q, pend_valid_d;

    // Committed display set
    coord_t     out_left_q, out_left_d;
    coord_t     out_right_q, out_right_d;
    coord_t     out_top_q, out_top_d;
    coord_t     out_bottom_q, out_bottom_d;
    logic [7:0] out_info_q, out_info_d;
    logic       out_valid_q, out_valid_d;

    logic       commit_evt;

    // Shared axis calculator: X operands in CALC_X, Y operands otherwise
    logic [7:0] axis_loc;
    coord_t     axis_ctb;
    coord_t     axis_lo;
    coord_t     axis_hi;

    assign axis_loc = (state_q == CALC_Y) ? cap_y_q : cap_x_q;
    assign axis_ctb = (state_q == CALC_Y) ? coord_t'(CTB_Y) : coord_t'(CTB_X);

    bbox_axis_calc u_axis (
        .loc_i (axis_loc),
        .ctb_i (axis_ctb),
        .lo_o  (axis_lo),
        .hi_o  (axis_hi)
    );

    assign commit_evt = frame_tick && pend_valid_q;

    // Next-state: commit of the old pending result, then FSM capture/compute
    always_comb begin
        state_d       = state_q;
        cap_x_d       = cap_x_q;
        cap_y_d       = cap_y_q;
        cap_info_d    = cap_info_q;
        calc_left_d   = calc_left_q;
        calc_right_d  = calc_right_q;
        pend_left_d   = pend_left_q;
        pend_right_d  = pend_right_q;
        pend_top_d    = pend_top_q;
        pend_bottom_d = pend_bottom_q;
        pend_info_d   = pend_info_q;
        pend_valid_d  = pend_valid_q;
        out_left_d    = out_left_q;
        out_right_d   = out_right_q;
        out_top_d     = out_top_q;
        out_bottom_d  = out_bottom_q;
        out_info_d    = out_info_q;
        out_valid_d   = out_valid_q;

        // Commit only what was already pending at the start of this cycle
        if (commit_evt) begin
            out_left_d   = pend_left_q;
            out_right_d  = pend_right_q;
            out_top_d    = pend_top_q;
            out_bottom_d = pend_bottom_q;
            out_info_d   = pend_info_q;
            out_valid_d  = 1'b1;
            pend_valid_d = 1'b0;
        end

        // A fresh update always (re)starts the calculation from CALC_X
        if (upd_sysregs) begin
            cap_x_d    = LocX_reg;
            cap_y_d    = LocY_reg;
            cap_info_d = BotInfo_reg;
            state_d    = CALC_X;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                CALC_X: begin
                    calc_left_d  = axis_lo;
                    calc_right_d = axis_hi;
                    state_d      = CALC_Y;
                end
                CALC_Y: begin
                    // Setting pending wins over the same-cycle commit clear
                    pend_left_d   = calc_left_q;
                    pend_right_d  = calc_right_q;
                    pend_top_d    = axis_lo;
                    pend_bottom_d = axis_hi;
                    pend_info_d   = cap_info_q;
                    pend_valid_d  = 1'b1;
                    state_d       = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cap_x_q       <= '0;
            cap_y_q       <= '0;
            cap_info_q    <= '0;
            calc_left_q   <= '0;
            calc_right_q  <= '0;
            pend_left_q   <= '0;
            pend_right_q  <= '0;
            pend_top_q    <= '0;
            pend_bottom_q <= '0;
            pend_info_q   <= '0;
            pend_valid_q  <= 1'b0;
            out_left_q    <= '0;
            out_right_q   <= '0;
            out_top_q     <= '0;
            out_bottom_q  <= '0;
            out_info_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_x_q       <= cap_x_d;
            cap_y_q       <= cap_y_d;
            cap_info_q    <= cap_info_d;
            calc_left_q   <= calc_left_d;
            calc_right_q  <= calc_right_d;
            pend_left_q   <= pend_left_d;
            pend_right_q  <= pend_right_d;
            pend_top_q    <= pend_top_d;
            pend_bottom_q <= pend_bottom_d;
            pend_info_q   <= pend_info_d;
            pend_valid_q  <= pend_valid_d;
            out_left_q    <= out_left_d;
            out_right_q   <= out_right_d;
            out_top_q     <= out_top_d;
            out_bottom_q  <= out_bottom_d;
            out_info_q    <= out_info_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign bbox_left     = out_left_q;
    assign bbox_right    = out_right_q;
    assign bbox_top      = out_top_q;
    assign bbox_bottom   = out_bottom_q;
    assign bot_info_disp = out_info_q;
    assign bbox_valid    = out_valid_q;
    assign busy          = (state_q != IDLE);

`ifdef ROBOT_BBOX_STATS_EN
    logic        coalesce_evt;
    logic [15:0] coalesced_cnt_q;
    logic [15:0] commit_cnt_q;

    // Lost work: an in-flight restart, or a completed result overwritten
    // before any frame boundary could commit it
    assign coalesce_evt = (upd_sysregs && (state_q != IDLE)) ||
                          (!upd_sysregs && (state_q == CALC_Y) &&
                           pend_valid_q && !frame_tick);

    // Free-running wrap-around statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coalesced_cnt_q <= '0;
            commit_cnt_q    <= '0;
        end else begin
            if (coalesce_evt) coalesced_cnt_q <= coalesced_cnt_q + 16'd1;
            if (commit_evt)   commit_cnt_q    <= commit_cnt_q + 16'd1;
        end
    end

    assign coalesced_cnt = coalesced_cnt_q;
    assign commit_cnt    = commit_cnt_q;
`endif

endmodule

// File: tb/tb_robot_bbox_pipe.sv
// Bench for robot_bbox_pipe: a table of capture/commit vectors plus hand
// sequences for early ticks, same-cycle update+tick, coalescing and reset
// mid-calculation. Expected boxes are queued when an update is driven and
// popped when a commit is observed.
module tb_robot_bbox_pipe;

  localparam int W = 72;  // {left, right, top, bottom, info}

  logic               clk;
  logic               reset;
  logic [7:0]         loc_x;
  logic [7:0]         loc_y;
  logic [7:0]         bot_info;
  logic               upd;
  logic               tick;
  logic signed [15:0] bbox_left;
  logic signed [15:0] bbox_right;
  logic signed [15:0] bbox_top;
  logic signed [15:0] bbox_bottom;
  logic [7:0]         bot_info_disp;
  logic               bbox_valid;
  logic               busy;
`ifdef ROBOT_BBOX_STATS_EN
  logic [15:0]        coalesced_cnt;
  logic [15:0]        commit_cnt;
`endif

  robot_bbox_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .LocX_reg      (loc_x),
    .LocY_reg      (loc_y),
    .BotInfo_reg   (bot_info),
    .upd_sysregs   (upd),
    .frame_tick    (tick),
    .bbox_left     (bbox_left),
    .bbox_right    (bbox_right),
    .bbox_top      (bbox_top),
    .bbox_bottom   (bbox_bottom),
    .bot_info_disp (bot_info_disp),
    .bbox_valid    (bbox_valid),
    .busy          (busy)
`ifdef ROBOT_BBOX_STATS_EN
    ,
    .coalesced_cnt (coalesced_cnt),
    .commit_cnt    (commit_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int n_cmp;
  int n_fail;

  typedef struct {
    logic [7:0]         x;
    logic [7:0]         y;
    logic [7:0]         info;
    logic signed [15:0] l;
    logic signed [15:0] r;
    logic signed [15:0] t;
    logic signed [15:0] b;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [W-1:0] pack_box(input logic signed [15:0] l, input logic signed [15:0] r,
                                            input logic signed [15:0] t, input logic signed [15:0] b,
                                            input logic [7:0] info);
    return {l, r, t, b, info};
  endfunction

  // Reference box: 6 px per cell, 34 px sprite, 14 px centre-to-bound
  function automatic logic [W-1:0] model_box(input int x, input int y, input logic [7:0] info);
    logic signed [15:0] l, r, t, b;
    l = 16'(x * 6 - 14);
    r = 16'(x * 6 + 5 + 14);
    t = 16'(y * 6 - 14);
    b = 16'(y * 6 + 5 + 14);
    return pack_box(l, r, t, b, info);
  endfunction

  function automatic logic [W-1:0] dut_box();
    return pack_box(bbox_left, bbox_right, bbox_top, bbox_bottom, bot_info_disp);
  endfunction

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // A commit must show the oldest still-live queued result and bbox_valid
  task automatic check_commit(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, dut_box());
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check_val(name, dut_box(), e);
      check_bit({name, "_valid"}, bbox_valid, 1'b1);
    end
  endtask

  task automatic check_hold(input string name, input logic exp_valid);
    check_val(name, dut_box(), last_exp);
    check_bit({name, "_valid"}, bbox_valid, exp_valid);
  endtask

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic do_reset();
    reset = 1'b1;
    upd   = 1'b0;
    tick  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    last_exp = '0;
  endtask

  // Drives a one-cycle update; supersede drops the uncommitted newest entry
  task automatic do_upd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] info,
                        input logic [W-1:0] exp, input bit supersede);
    if (supersede && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(exp);
    loc_x    = x;
    loc_y    = y;
    bot_info = info;
    upd      = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_bit(name, busy, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    last_exp = '0;
    loc_x    = '0;
    loc_y    = '0;
    bot_info = '0;
    upd      = 1'b0;
    tick     = 1'b0;
    reset    = 1'b1;

    vecs[0] = '{x: 8'd10,  y: 8'd20,  info: 8'h12, l: 16'sd46,  r: 16'sd79,  t: 16'sd106, b: 16'sd139};
    vecs[1] = '{x: 8'd0,   y: 8'd127, info: 8'h05, l: -16'sd14, r: 16'sd19,  t: 16'sd748, b: 16'sd781};
    vecs[2] = '{x: 8'd127, y: 8'd0,   info: 8'hA3, l: 16'sd748, r: 16'sd781, t: -16'sd14, b: 16'sd19};
    vecs[3] = '{x: 8'd1,   y: 8'd1,   info: 8'h70, l: -16'sd8,  r: 16'sd25,  t: -16'sd8,  b: 16'sd25};
    vecs[4] = '{x: 8'd64,  y: 8'd100, info: 8'hF7, l: 16'sd370, r: 16'sd403, t: 16'sd586, b: 16'sd619};
    for (int i = 5; i < 12; i++) begin
      logic [W-1:0] m;
      vecs[i].x    = 8'($urandom_range(0, 127));
      vecs[i].y    = 8'($urandom_range(0, 127));
      vecs[i].info = 8'($urandom_range(0, 255));
      m = model_box(int'(vecs[i].x), int'(vecs[i].y), vecs[i].info);
      {vecs[i].l, vecs[i].r, vecs[i].t, vecs[i].b} = m[W-1:8];
    end

    // Reset state
    do_reset();
    check_hold("reset_outputs", 1'b0);
    check_bit("reset_busy", busy, 1'b0);

    // Tick during CALC_Y commits nothing; the next tick commits
    do_upd(8'd10, 8'd20, 8'h12, model_box(10, 20, 8'h12), 1'b0);
    check_bit("busy_in_calc", busy, 1'b1);
    @(negedge clk);
    pulse_tick();
    check_hold("early_tick_hold", 1'b0);
    pulse_tick();
    check_commit("early_tick_commit");

    // Table vectors, commit after a random idle gap
    for (int i = 0; i < 12; i++) begin
      do_upd(vecs[i].x, vecs[i].y, vecs[i].info,
             pack_box(vecs[i].l, vecs[i].r, vecs[i].t, vecs[i].b, vecs[i].info), 1'b0);
      wait_idle($sformatf("vec%0d_idle", i));
      idle_cycles($urandom_range(0, 3));
      check_hold($sformatf("vec%0d_pre", i), 1'b1);
      pulse_tick();
      check_commit($sformatf("vec%0d", i));
    end

    // Tick with nothing pending holds the outputs
    pulse_tick();
    check_hold("empty_tick_hold", 1'b1);

    // Update and tick in the same IDLE cycle: old pending now, new one next tick
    do_upd(8'd10, 8'd20, 8'h12, model_box(10, 20, 8'h12), 1'b0);
    wait_idle("same_cycle_idle");
    exp_q.push_back(pack_box(16'sd52, 16'sd85, 16'sd106, 16'sd139, 8'h34));
    loc_x    = 8'd11;
    loc_y    = 8'd20;
    bot_info = 8'h34;
    upd      = 1'b1;
    tick     = 1'b1;
    @(negedge clk);
    upd  = 1'b0;
    tick = 1'b0;
    check_commit("same_cycle_old");
    wait_idle("same_cycle_idle2");
    pulse_tick();
    check_commit("same_cycle_new");

    // Restart mid-calculation: only the latest update commits
    do_reset();
    do_upd(8'd5, 8'd9, 8'h31, model_box(5, 9, 8'h31), 1'b0);
    do_upd(8'd7, 8'd9, 8'h32, pack_box(16'sd28, 16'sd61, 16'sd40, 16'sd73, 8'h32), 1'b1);
    wait_idle("coalesce_idle");
    pulse_tick();
    check_commit("coalesce_commit");
`ifdef ROBOT_BBOX_STATS_EN
    check_val("coalesced_cnt", W'(coalesced_cnt), W'(16'd1));
    check_val("commit_cnt", W'(commit_cnt), W'(16'd1));
`endif

    // Completed result overwritten before a tick: the later one commits
    do_upd(8'd3, 8'd4, 8'h01, model_box(3, 4, 8'h01), 1'b0);
    wait_idle("overwrite_idle1");
    do_upd(8'd90, 8'd33, 8'h02, model_box(90, 33, 8'h02), 1'b1);
    wait_idle("overwrite_idle2");
    pulse_tick();
    check_commit("overwrite_commit");

    // Reset in CALC_Y discards everything
    do_upd(8'd50, 8'd60, 8'h44, model_box(50, 60, 8'h44), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    last_exp = '0;
    check_hold("midcalc_reset", 1'b0);
    check_bit("midcalc_reset_busy", busy, 1'b0);
    reset = 1'b0;
    idle_cycles(4);
    pulse_tick();
    check_hold("post_reset_tick", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
